// File: rtl/rcu_pkg.sv
// Shared rename-control types and constants for the physical-register release path.
package rcu_pkg;

  localparam int PREG_WIDTH      = 6;
  localparam int STAGE_DEPTH_DEF = 4;
  localparam int STAGE_PTR_W     = (STAGE_DEPTH_DEF > 1) ? $clog2(STAGE_DEPTH_DEF) : 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rel_state_e;

  function automatic int stage_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prf_release_stage.sv
// Two-write / one-read circular staging buffer feeding the free-list write port.
// Lane 0 lands at the tail, lane 1 at the following slot (or the tail if lane 0 is idle).
module prf_release_stage
  import rcu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = rcu_pkg::PREG_WIDTH,
  localparam int PTR_W = stage_ptr_w(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_ptr_r;
  logic [PTR_W-1:0] tail_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] slot0_s;
  logic [PTR_W-1:0] slot1_s;
  logic [1:0]       push_num_s;

  // Write-slot selection and number of entries entering this cycle
  always_comb begin
    slot0_s    = tail_ptr_r;
    slot1_s    = tail_ptr_r;
    push_num_s = {1'b0, push0} + {1'b0, push1};
    if (push0) begin
      slot1_s = tail_ptr_r + PTR_W'(1);
    end else begin
      slot1_s = tail_ptr_r;
    end
  end

  // Entry storage; data needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_r[slot0_s] <= data0;
    end
    if (push1) begin
      mem_r[slot1_s] <= data1;
    end
  end

  // Pointers and occupancy; wrap relies on DEPTH being a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_r <= '0;
      tail_ptr_r <= '0;
      count_r    <= '0;
    end else begin
      head_ptr_r <= head_ptr_r + PTR_W'(pop);
      tail_ptr_r <= tail_ptr_r + PTR_W'(push_num_s);
      count_r    <= count_r + CNT_W'(push_num_s) - CNT_W'(pop);
    end
  end

  assign head  = mem_r[head_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/prf_release_unit.sv
// Free-list producer: fills the initial free pool after reset, then serializes committed releases.
// Optional macro PRF_RELEASE_X0_FILTER_EN drops released index 0 instead of staging it.
module prf_release_unit
  import rcu_pkg::*;
#(
  parameter int PREG_WIDTH  = rcu_pkg::PREG_WIDTH,
  parameter int INIT_BASE   = 32,
  parameter int INIT_NUM    = 32,
  parameter int STAGE_DEPTH = 4,
  localparam int CNT_W  = $clog2(STAGE_DEPTH) + 1,
  localparam int INIT_W = (INIT_NUM > 1) ? $clog2(INIT_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rel_vld_i,
  input  logic [PREG_WIDTH-1:0] rel_prd0_i,
  input  logic [PREG_WIDTH-1:0] rel_prd1_i,
  output logic                  rel_rdy_o,
  input  logic                  fl_full_i,
  output logic                  fl_wr_en_o,
  output logic [PREG_WIDTH-1:0] fl_wdata_o,
  output logic                  init_done_o,
  output logic [CNT_W-1:0]      stage_cnt_o
);

  rel_state_e            state_r;
  rel_state_e            state_nxt_s;
  logic [INIT_W-1:0]     init_cnt_r;
  logic                  init_adv_s;
  logic                  init_last_s;
  logic [CNT_W-1:0]      stage_cnt_s;
  logic [PREG_WIDTH-1:0] head_s;
  logic                  ready_s;
  logic                  pop_s;
  logic                  keep0_s;
  logic                  keep1_s;
  logic                  push0_s;
  logic                  push1_s;

  assign init_adv_s  = (state_r == ST_INIT) & ~fl_full_i;
  assign init_last_s = (init_cnt_r == INIT_W'(INIT_NUM - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: leave INIT on the accepted push of the last pool entry
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_adv_s && init_last_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Init pool counter, advances only on pushes the free list accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_r <= '0;
    end else if (init_adv_s) begin
      init_cnt_r <= init_cnt_r + INIT_W'(1);
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end

  // FSM outputs; everything is forced quiet while rst is high
  always_comb begin
    ready_s     = 1'b0;
    pop_s       = 1'b0;
    fl_wr_en_o  = 1'b0;
    fl_wdata_o  = '0;
    init_done_o = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          fl_wr_en_o = ~fl_full_i;
          fl_wdata_o = PREG_WIDTH'(INIT_BASE) + PREG_WIDTH'(init_cnt_r);
        end
        ST_RUN: begin
          // Readiness looks only at the registered count so a same-cycle pop never widens it
          ready_s     = (stage_cnt_s <= CNT_W'(STAGE_DEPTH - 2));
          pop_s       = (stage_cnt_s != '0) & ~fl_full_i;
          fl_wr_en_o  = pop_s;
          fl_wdata_o  = head_s;
          init_done_o = 1'b1;
        end
        default: begin
          fl_wr_en_o = 1'b0;
        end
      endcase
    end
  end

`ifdef PRF_RELEASE_X0_FILTER_EN
  // Index 0 is handshaken but never staged, so it can never be re-allocated
  assign keep0_s = (rel_prd0_i != '0);
  assign keep1_s = (rel_prd1_i != '0);
`else
  assign keep0_s = 1'b1;
  assign keep1_s = 1'b1;
`endif

  assign push0_s = ready_s & rel_vld_i[0] & keep0_s;
  assign push1_s = ready_s & rel_vld_i[1] & keep1_s;

  prf_release_stage #(
    .DEPTH (STAGE_DEPTH),
    .WIDTH (PREG_WIDTH)
  ) u_stage (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0_s),
    .push1 (push1_s),
    .data0 (rel_prd0_i),
    .data1 (rel_prd1_i),
    .pop   (pop_s),
    .head  (head_s),
    .count (stage_cnt_s)
  );

  assign rel_rdy_o   = ready_s;
  assign stage_cnt_o = rst ? '0 : stage_cnt_s;

endmodule

// File: tb/tb_prf_release_unit.sv
// Self-checking bench for prf_release_unit: directed table, corner sequences, random vs queue model.
module tb_prf_release_unit;

  localparam int PW = 6;
  localparam int IB = 32;
  localparam int IN = 32;
  localparam int SD = 4;
  localparam int CW = $clog2(SD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rel_vld;
  logic [PW-1:0] prd0;
  logic [PW-1:0] prd1;
  logic          full;
  logic          rdy;
  logic          wr_en;
  logic [PW-1:0] wdata;
  logic          done;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  prf_release_unit #(
    .PREG_WIDTH (PW),
    .INIT_BASE  (IB),
    .INIT_NUM   (IN),
    .STAGE_DEPTH(SD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rel_vld_i  (rel_vld),
    .rel_prd0_i (prd0),
    .rel_prd1_i (prd1),
    .rel_rdy_o  (rdy),
    .fl_full_i  (full),
    .fl_wr_en_o (wr_en),
    .fl_wdata_o (wdata),
    .init_done_o(done),
    .stage_cnt_o(cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: init flag + counter, and a plain queue of staged indices
  bit       m_init = 1'b1;
  int       m_icnt = 0;
  int       m_q[$];
  bit       e_wr, e_rdy, e_done, e_wd_chk;
  int       e_wdata, e_cnt;
  int       wr_log[$];

  typedef struct {
    logic       r;
    logic [1:0] v;
    int         p0, p1;
    logic       f;
    logic       x_wr;
    int         x_wd;
    logic       x_rdy;
    int         x_cnt;
    logic       x_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit keep(input int p);
`ifdef PRF_RELEASE_X0_FILTER_EN
    return p != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_eval();
    e_wd_chk = 1'b1;
    if (rst) begin
      e_wr = 0; e_rdy = 0; e_done = 0; e_wdata = 0; e_cnt = 0;
    end else if (m_init) begin
      e_wr = !full; e_rdy = 0; e_done = 0; e_cnt = 0;
      e_wdata = (IB + m_icnt) % (1 << PW);
    end else begin
      e_done  = 1;
      e_cnt   = m_q.size();
      e_rdy   = (SD - m_q.size()) >= 2;
      e_wr    = (m_q.size() != 0) && !full;
      e_wd_chk = e_wr;
      e_wdata = (m_q.size() != 0) ? m_q[0] : 0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_init = 1; m_icnt = 0; m_q.delete();
    end else if (m_init) begin
      if (!full) begin
        m_icnt++;
        if (m_icnt == IN) m_init = 0;
      end
    end else begin
      if (e_wr) void'(m_q.pop_front());
      if (e_rdy) begin
        if (rel_vld[0] && keep(int'(prd0))) m_q.push_back(int'(prd0));
        if (rel_vld[1] && keep(int'(prd1))) m_q.push_back(int'(prd1));
      end
    end
  endtask

  // Apply inputs, then compare DUT against the model mid-cycle
  task automatic drive(input logic r, input logic [1:0] v, input int p0, input int p1, input logic f);
    rst = r; rel_vld = v; prd0 = PW'(p0); prd1 = PW'(p1); full = f;
    #2;
    model_eval();
    chk("m_wr_en", 32'(wr_en), 32'(e_wr));
    chk("m_rdy", 32'(rdy), 32'(e_rdy));
    chk("m_done", 32'(done), 32'(e_done));
    chk("m_cnt", 32'(cnt), 32'(e_cnt));
    if (e_wd_chk) chk("m_wdata", 32'(wdata), 32'(e_wdata));
    if (wr_en === 1'b1) wr_log.push_back(int'(wdata));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t tbl[$];
  int   accepted;

  initial begin
    rst = 1'b1; rel_vld = 2'b00; prd0 = '0; prd1 = '0; full = 1'b0;

    // Reset, first init pushes, and a 3-cycle free-list stall at init_cnt 5
    tbl.push_back('{1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 0,  1'b0, 0, 1'b0});
    tbl.push_back('{1'b1, 2'd3, 1, 2, 1'b0, 1'b0, 0,  1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd3, 5, 6, 1'b0, 1'b1, 32, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 33, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 34, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 35, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 36, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b1, 1'b0, 37, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 4, 0, 1'b1, 1'b0, 37, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b1, 1'b0, 37, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 37, 1'b0, 0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 38, 1'b0, 0, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].p0, tbl[i].p1, tbl[i].f);
      chk("t_wr_en", 32'(wr_en), 32'(tbl[i].x_wr));
      chk("t_wdata", 32'(wdata), 32'(tbl[i].x_wd));
      chk("t_rdy", 32'(rdy), 32'(tbl[i].x_rdy));
      chk("t_cnt", 32'(cnt), 32'(tbl[i].x_cnt));
      chk("t_done", 32'(done), 32'(tbl[i].x_done));
      tick();
    end

    // Remainder of the init pool, no back-pressure
    for (int i = 7; i < IN; i++) begin
      drive(1'b0, 2'd0, 0, 0, 1'b0);
      chk("init_seq", 32'(wdata), 32'(IB + i));
      chk("init_wr", 32'(wr_en), 32'd1);
      tick();
    end

    // Dual release 12/7 every cycle; readiness alternates once the buffer hits 3
    wr_log.delete();
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 2'd3, 12, 7, 1'b0);
      if (i == 0) begin
        chk("run_done", 32'(done), 32'd1);
        chk("run_rdy", 32'(rdy), 32'd1);
      end
      if (i == 2) chk("rdy_drop_at_3", 32'(rdy), 32'd0);
      if (rdy === 1'b1) accepted++;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'd0, 0, 0, 1'b0);
      tick();
    end
    chk("dual_accepted", 32'(accepted), 32'd7);
    chk("dual_no_loss", 32'(wr_log.size()), 32'(2 * accepted));
    for (int k = 0; k < wr_log.size(); k++)
      chk("dual_order", 32'(wr_log[k]), (k % 2 == 1) ? 32'd7 : 32'd12);

    // Full free list with 4 staged entries, then drain in order
    drive(1'b0, 2'd3, 1, 2, 1'b1); tick();
    drive(1'b0, 2'd3, 3, 4, 1'b1); tick();
    drive(1'b0, 2'd3, 5, 6, 1'b1);
    chk("full_rdy", 32'(rdy), 32'd0);
    chk("full_cnt", 32'(cnt), 32'd4);
    chk("full_wr", 32'(wr_en), 32'd0);
    tick();
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 0, 0, 1'b0);
      tick();
    end
    chk("full_drain_n", 32'(wr_log.size()), 32'd4);
    for (int k = 0; k < wr_log.size(); k++)
      chk("full_drain_order", 32'(wr_log[k]), 32'(k + 1));

    // Lane 0 carries index 0, lane 1 carries 9
    drive(1'b0, 2'd3, 0, 9, 1'b1); tick();
    drive(1'b0, 2'd0, 0, 0, 1'b1);
`ifdef PRF_RELEASE_X0_FILTER_EN
    chk("x0_cnt", 32'(cnt), 32'd1);
`else
    chk("x0_cnt", 32'(cnt), 32'd2);
`endif
    tick();
    wr_log.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 0, 0, 1'b0);
      tick();
    end
`ifdef PRF_RELEASE_X0_FILTER_EN
    chk("x0_writes", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) chk("x0_first", 32'(wr_log[0]), 32'd9);
`else
    chk("x0_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() > 0) chk("x0_first", 32'(wr_log[0]), 32'd0);
`endif

    // Reset with 3 staged entries discards them and restarts init
    drive(1'b0, 2'd3, 10, 11, 1'b1); tick();
    drive(1'b0, 2'd2, 0, 13, 1'b1);  tick();
    drive(1'b0, 2'd0, 0, 0, 1'b1);
    chk("pre_rst_cnt", 32'(cnt), 32'd3);
    tick();
    drive(1'b1, 2'd0, 0, 0, 1'b0);
    chk("in_rst_wr", 32'(wr_en), 32'd0);
    tick();
    drive(1'b0, 2'd0, 0, 0, 1'b0);
    chk("post_rst_cnt", 32'(cnt), 32'd0);
    chk("post_rst_wdata", 32'(wdata), 32'(IB));
    chk("post_rst_done", 32'(done), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 63)),
            ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 63)),
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
